// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - round-robin shared signed adder with two-stage valid/ready pipeline
`timescale 1ns/1ps
module adder_share_sched #(
  parameter int N_REQ     = 4,
  parameter int INP_WIDTH = 8,
  parameter int OUT_WIDTH = 9,
  parameter int ID_WIDTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*INP_WIDTH-1:0]  a_bus,
  input  logic [N_REQ*INP_WIDTH-1:0]  b_bus,
  output logic [N_REQ-1:0]            gnt,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_sum,
  output logic [ID_WIDTH-1:0]         out_id,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]                r_ptr;
  logic                         r_v1;
  logic [ID_WIDTH-1:0]          r_id1;
  logic signed [INP_WIDTH-1:0]  r_a1;
  logic signed [INP_WIDTH-1:0]  r_b1;
  logic                         r_out_valid;
  logic [ID_WIDTH-1:0]          r_out_id;
  logic signed [OUT_WIDTH-1:0]  r_out_sum;

  logic                         w_en;
  logic                         w_found;
  logic                         w_grant;
  logic [IW-1:0]                w_win;
  logic [IW-1:0]                w_ptr_next;
  logic [INP_WIDTH-1:0]         w_a_sel;
  logic [INP_WIDTH-1:0]         w_b_sel;

  // A stalled output freezes every stage, including the arbiter.
  assign w_en    = !r_out_valid || out_ready;
  assign w_grant = w_found && w_en && rst_n;

  // Search from r_ptr upward, wrapping at N_REQ; IW+1 bits hold the unwrapped index.
  always_comb begin : arb_search
    logic [IW:0] v_pos;
    w_found = 1'b0;
    w_win   = '0;
    v_pos   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      v_pos = {1'b0, r_ptr} + (IW+1)'(off);
      if (v_pos >= (IW+1)'(N_REQ)) begin
        v_pos = v_pos - (IW+1)'(N_REQ);
      end
      if (!w_found && req[v_pos[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_pos[IW-1:0];
      end
    end
  end

  always_comb begin : grant_mux
    gnt     = '0;
    w_a_sel = '0;
    w_b_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == IW'(k)) begin
        gnt[k]  = w_grant;
        w_a_sel = a_bus[k*INP_WIDTH +: INP_WIDTH];
        w_b_sel = b_bus[k*INP_WIDTH +: INP_WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_win == IW'(N_REQ-1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Stage 1: capture the winner's operands; contents are don't-care when r_v1 is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_id1 <= '0;
      r_a1  <= '0;
      r_b1  <= '0;
    end else if (w_en) begin
      r_v1 <= w_grant;
      if (w_grant) begin
        r_id1 <= ID_WIDTH'(w_win);
        r_a1  <= w_a_sel;
        r_b1  <= w_b_sel;
      end
    end
  end

  // Stage 2: one-bit sign extension makes the sum exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_sum   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_v1;
      r_out_id    <= r_id1;
      r_out_sum   <= OUT_WIDTH'(r_a1) + OUT_WIDTH'(r_b1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign out_sum   = r_out_sum;
  assign busy      = r_v1 || r_out_valid;

endmodule

// File: tb/tb_adder_share_sched.sv
// tb/tb_adder_share_sched.sv - directed self-checking bench for adder_share_sched
`timescale 1ns/1ps
module tb_adder_share_sched;

  localparam int N  = 4;
  localparam int IW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*IW-1:0]   a_bus;
  logic [N*IW-1:0]   b_bus;
  logic [N-1:0]      gnt;
  logic              out_valid;
  logic signed [8:0] out_sum;
  logic [1:0]        out_id;
  logic              out_ready;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt [N];

  adder_share_sched #(.N_REQ(N), .INP_WIDTH(IW), .OUT_WIDTH(9), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .out_valid(out_valid), .out_sum(out_sum), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    logic [31:0] va;
    logic [31:0] vb;
    va = a;
    vb = b;
    a_bus[i*IW +: IW] = va[7:0];
    b_bus[i*IW +: IW] = vb[7:0];
  endtask

  // Hand-derived schedule for req=1111 from reset with out_ready low on cycles 5..7.
  logic [3:0] exp_gnt [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic       exp_vld [16] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int         exp_id  [16] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 0, 1, 2, 3, 0, 0, 0};
  int         exp_sum [4]  = '{11, 22, 33, -10};

  initial begin
    rst_n     = 1'b0;
    req       = '1;
    a_bus     = '0;
    b_bus     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) xfer_cnt[i] = 0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sum", 32'(out_sum), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single requester: 5 + -3
    req = '0;
    rst_n = 1'b1;
    set_op(0, 5, -3);
    req = 4'b0001;
    #1;
    chk("single_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    #1;
    chk("single_t1_valid", 32'(out_valid), 32'h0);
    chk("single_t1_busy", 32'(busy), 32'h1);
    tick();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_sum", 32'(out_sum), 32'd2);
    chk("single_id", 32'(out_id), 32'h0);
    tick();
    chk("single_drain", 32'(out_valid), 32'h0);

    // Extremes on requesters 1..3, back to back
    set_op(1, -128, -128);
    req = 4'b0010;
    #1;
    chk("ext_gnt1", 32'(gnt), 32'b0010);
    tick();
    set_op(2, 127, 127);
    req = 4'b0100;
    #1;
    chk("ext_gnt2", 32'(gnt), 32'b0100);
    tick();
    set_op(3, -128, 127);
    req = 4'b1000;
    #1;
    chk("ext_gnt3", 32'(gnt), 32'b1000);
    chk("ext_sum_neg", 32'(out_sum), -32'sd256);
    chk("ext_id1", 32'(out_id), 32'd1);
    tick();
    req = '0;
    #1;
    chk("ext_sum_pos", 32'(out_sum), 32'd254);
    chk("ext_id2", 32'(out_id), 32'd2);
    tick();
    chk("ext_sum_m1", 32'(out_sum), -32'sd1);
    chk("ext_id3", 32'(out_id), 32'd3);
    chk("ext_valid", 32'(out_valid), 32'h1);
    tick();

    // Pointer fairness: ptr is 0 here; grant 1, then 2 with req=0101, then 0
    req = 4'b0010;
    #1;
    chk("fair_gnt1", 32'(gnt), 32'b0010);
    tick();
    req = 4'b0101;
    #1;
    chk("fair_gnt2", 32'(gnt), 32'b0100);
    tick();
    chk("fair_gnt0", 32'(gnt), 32'b0001);
    tick();
    req = '0;
    tick();
    tick();
    tick();
    chk("fair_idle", 32'(busy), 32'h0);

    // All four from reset, with a three-cycle output stall
    rst_n = 1'b0;
    tick();
    set_op(0, 10, 1);
    set_op(1, 20, 2);
    set_op(2, 30, 3);
    set_op(3, 40, -50);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) tick();
      req       = (c < 12) ? 4'b1111 : 4'b0000;
      out_ready = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("rr_gnt_c%0d", c), 32'(gnt), 32'(exp_gnt[c]));
      chk($sformatf("rr_valid_c%0d", c), 32'(out_valid), 32'(exp_vld[c]));
      if (exp_vld[c]) begin
        chk($sformatf("rr_id_c%0d", c), 32'(out_id), 32'(exp_id[c]));
        chk($sformatf("rr_sum_c%0d", c), 32'(out_sum), 32'(exp_sum[exp_id[c]]));
      end
      if (out_valid && out_ready) xfer_cnt[out_id]++;
    end
    chk("sb_id0", 32'(xfer_cnt[0]), 32'd3);
    chk("sb_id1", 32'(xfer_cnt[1]), 32'd2);
    chk("sb_id2", 32'(xfer_cnt[2]), 32'd2);
    chk("sb_id3", 32'(xfer_cnt[3]), 32'd2);
    chk("sb_busy", 32'(busy), 32'h0);

    // Reset mid-stream with both stages full
    req = 4'b1111;
    tick();
    tick();
    #1;
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    chk("mid_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_sum", 32'(out_sum), 32'h0);
    chk("mid_id", 32'(out_id), 32'h0);
    chk("mid_gnt", 32'(gnt), 32'h0);
    tick();
    req = 4'b1010;
    rst_n = 1'b1;
    #1;
    chk("mid_first_gnt", 32'(gnt), 32'b0010);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
